multiplicador_8bits_seq: RTL and testbench

- Sequential shift-and-add unsigned multiplier for the 8-bit ALU. It is the inverse operation to the ALU divide path.
- Computes a full-width product P = A × B over WIDTH clock cycles using a single adder, instead of a combinational array.
- Used by the ALU control for the MUL opcode. The start/busy/done handshake lets the ALU sequencer stall while the product is formed.

---
 rtl/multiplicador_8bits_seq_pkg.sv | 17 +
 rtl/multiplicador_8bits_seq.sv | 93 +++++++++
 tb/tb_multiplicador_8bits_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/multiplicador_8bits_seq_pkg.sv
// Shared ALU definitions used by the sequential multiplier and the ALU control.
// Holds the default operand width, the FSM state encoding and the MUL opcode.
package multiplicador_8bits_seq_pkg;

    localparam int MUL_WIDTH = 8;

    // Opcode the ALU control decodes to launch this multiplier.
    localparam logic [3:0] OPC_MUL = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } mul_state_e;

endpackage

// File: rtl/multiplicador_8bits_seq.sv
// Shift-and-add unsigned multiplier: one adder and WIDTH iterations produce a 2*WIDTH product,
// with a start/busy/done handshake so the ALU sequencer can stall on MUL.
module multiplicador_8bits_seq
    import multiplicador_8bits_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(WIDTH);

    mul_state_e             state_q, state_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [CW-1:0]          count_q, count_d;
    logic [2*WIDTH-1:0]     p_q, p_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            p_q      <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (count_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Iterations run while count < WIDTH; the edge that sees count == WIDTH publishes the
    // product, so P never shows a partial sum.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        p_d      = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, A};
                    mplier_d = B;
                    count_d  = '0;
                end
            end
            ST_RUN: begin
                if (count_q == LAST_CNT) begin
                    p_d = acc_q;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
        P    = p_q;
    end

endmodule

// File: tb/tb_multiplicador_8bits_seq.sv
// Self-checking bench for the sequential multiplier: directed vectors, busy-start and
// mid-operation reset corner cases, back-to-back issue and a random sweep against A*B.
module tb_multiplicador_8bits_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs [6];

    multiplicador_8bits_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive start for one cycle; returns at the falling edge after the accepting edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe the operation accepted on the previous rising edge. Optionally pulses a second
    // start at offset inj_at, and scrambles A/B during the run. With b2b set, returns right
    // after the done cycle so the caller can issue the next start immediately.
    task automatic wait_done(input logic [15:0] exp, input string tag, input int inj_at,
                             input logic [7:0] ia, input logic [7:0] ib, input bit b2b);
        logic [15:0] p_before;
        int          lat;
        int          ndone;
        bit          hold_err;
        p_before = P;
        lat      = 0;
        ndone    = 0;
        hold_err = 1'b0;
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) lat = n;
                check({tag, " P at done"}, 32'(P), 32'(exp));
            end else if (lat == 0 && P !== p_before) begin
                hold_err = 1'b1;
            end
            if (inj_at > 0 && n == inj_at + 1) start = 1'b0;
            if (inj_at > 0 && n == inj_at) begin
                A = ia;
                B = ib;
                start = 1'b1;
            end else if (n == 2) begin
                A = 8'($urandom);
                B = 8'($urandom);
            end
            if (b2b && done) break;
        end
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " P hold before done"}, 32'(hold_err), 32'd0);
        if (!b2b) begin
            check({tag, " done count"}, 32'(ndone), 32'd1);
            check({tag, " busy idle"}, 32'(busy), 32'd0);
            check({tag, " P stable"}, 32'(P), 32'(exp));
        end
        $display("op %s: P=0x%04h expected 0x%04h latency %0d", tag, P, exp, lat);
    endtask

    initial begin
        int ndone;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rexp;

        vecs[0] = '{8'h0F, 8'h0F, 16'h00E1};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'h00, 8'hA5, 16'h0000};
        vecs[3] = '{8'hA5, 8'h00, 16'h0000};
        vecs[4] = '{8'h01, 8'hC3, 16'h00C3};
        vecs[5] = '{8'h80, 8'h80, 16'h4000};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset P", 32'(P), 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("idle no activity", 32'(ndone), 32'd0);

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_done(vecs[i].p, $sformatf("vec%0d", i), 0, 8'h0, 8'h0, 1'b0);
        end

        // Second start while in RUN must be ignored.
        start_op(8'h0C, 8'h0D);
        wait_done(16'h009C, "busy-start", 3, 8'h02, 8'h02, 1'b0);
        check("div quotient", 32'(P / 16'h000D), 32'h0C);
        check("div remainder", 32'(P % 16'h000D), 32'h0);

        // Reset during RUN discards the operation.
        start_op(8'h12, 8'h34);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst P", 32'(P), 32'h0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        ndone = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no done", 32'(ndone), 32'd0);
        $display("op midrst: P=0x%04h busy=%0d", P, busy);
        start_op(8'h12, 8'h34);
        wait_done(16'h03A8, "after-rst", 0, 8'h0, 8'h0, 1'b0);

        // Back-to-back: next start in the cycle right after done.
        start_op(8'h07, 8'h09);
        wait_done(16'h003F, "b2b-first", 0, 8'h0, 8'h0, 1'b1);
        start_op(8'h80, 8'h02);
        wait_done(16'h0100, "b2b-second", 0, 8'h0, 8'h0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rexp = 16'(int'(ra) * int'(rb));
            start_op(ra, rb);
            wait_done(rexp, $sformatf("rand%0d %02h*%02h", i, ra, rb), 0, 8'h0, 8'h0,
                      (i % 2) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
